// File: rtl/burst_pkg.sv
// Shared widths, controller slot constants and the PTS word-count helper
// for the burst controller and its address datapath.
package burst_pkg;

   localparam int DEF_LEN_W     = 4;
   localparam int DEF_ADDR_W    = 16;
   localparam int DEF_NIB_W     = 4;
   localparam int DEF_ADDR_STEP = 1;

   localparam logic [1:0] WORD_SEL_ALL = 2'b11;

   // Controller sequence slots: idle, length field, address field, first beat, stop check
   localparam int SLOT_IDLE = 0;
   localparam int SLOT_LEN  = 4;
   localparam int SLOT_ADDR = 20;
   localparam int SLOT_BEAT = 21;
   localparam int SLOT_STOP = 22;

   function automatic int pts_bit_count(input logic [1:0] word_sel, input int nib_w,
                                        input int addr_w);
      int n;
      n = (int'(word_sel) + 1) * nib_w;
      return (n > addr_w) ? addr_w : n;
   endfunction

endpackage

// File: rtl/burst_pts.sv
// Parallel-to-serial address shifter: emits the top (word_sel+1)*NIB_W bits MSB first,
// one registered bit per send (1-cycle latency), then a one-cycle done pulse.
module burst_pts
   import burst_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NIB_W  = DEF_NIB_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic              load,
   input  logic              send,
   input  logic [1:0]        word_sel,
   input  logic [ADDR_W-1:0] par_in,
   output logic              pts_bit,
   output logic              pts_valid,
   output logic              pts_done
);

   localparam int CNT_W = $clog2(ADDR_W + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [ADDR_W-1:0] sr_q, sr_d;
   logic [CNT_W-1:0]  left_q, left_d;
   logic              bit_q, bit_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;

   always_comb begin
      sr_d    = sr_q;
      left_d  = left_q;
      bit_d   = bit_q;
      valid_d = valid_q;
      done_d  = 1'b0;
      // The synchronous clear works even while the shifter is not enabled
      if (clr) begin
         sr_d    = '0;
         left_d  = '0;
         bit_d   = 1'b0;
         valid_d = 1'b0;
      end else if (en) begin
         if (load) begin
            sr_d    = par_in;
            left_d  = CNT_W'(pts_bit_count(word_sel, NIB_W, ADDR_W));
            bit_d   = 1'b0;
            valid_d = 1'b0;
         end else if (send && (left_q != '0)) begin
            bit_d   = sr_q[ADDR_W-1];
            sr_d    = {sr_q[ADDR_W-2:0], 1'b0};
            left_d  = left_q - CNT_ONE;
            valid_d = 1'b1;
         end else if (valid_q && (left_q == '0)) begin
            done_d  = 1'b1;
            bit_d   = 1'b0;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q    <= '0;
         left_q  <= '0;
         bit_q   <= 1'b0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         left_q  <= left_d;
         bit_q   <= bit_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign pts_bit   = bit_q;
   assign pts_valid = valid_q;
   assign pts_done  = done_q;

endmodule

// File: rtl/burst_addr_datapath.sv
// Burst datapath: captures serial length/address, counts beats, steps the address and
// serialises it to the MRAM pin; stop_signal is registered, addr_sout mux is combinational.
module burst_addr_datapath
   import burst_pkg::*;
#(
   parameter int LEN_W     = DEF_LEN_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int NIB_W     = DEF_NIB_W,
   parameter int ADDR_STEP = DEF_ADDR_STEP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              len_sin,
   input  logic              addr_sin,
   input  logic              burst_len_en,
   input  logic              send_burst_len_data,
   input  logic              initial_addr_en,
   input  logic              send_addr_data,
   input  logic              counter_en,
   input  logic              adder_en,
   input  logic              addr_PTS_out_rst,
   input  logic              addr_PTS_out_en,
   input  logic              addr_PTS_out_load,
   input  logic              addr_PTS_out_send_data,
   input  logic [1:0]        addr_PTS_out_word_sel,
   input  logic              addr_sel,
   output logic              stop_signal,
   output logic              addr_sout,
   output logic              pts_valid,
   output logic              pts_done,
   output logic [ADDR_W-1:0] cur_addr
);

   localparam logic [LEN_W:0]    BEAT_ONE = 1;
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);

   logic [LEN_W-1:0]  len_sr_q, len_sr_d;
   logic [LEN_W-1:0]  len_reg_q, len_reg_d;
   logic              len_loaded_q, len_loaded_d;
   logic [LEN_W:0]    beat_cnt_q, beat_cnt_d;
   logic              stop_q, stop_d;
   logic [ADDR_W-1:0] addr_sr_q, addr_sr_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [LEN_W:0]    target, target_d;
   logic              beat_take;
   logic              pts_bit;

   always_comb begin
      len_sr_d     = len_sr_q;
      addr_sr_d    = addr_sr_q;
      len_reg_d    = len_reg_q;
      len_loaded_d = len_loaded_q;
      beat_cnt_d   = beat_cnt_q;
      cur_addr_d   = cur_addr_q;

      if (burst_len_en)    len_sr_d  = {len_sr_q[LEN_W-2:0], len_sin};
      if (initial_addr_en) addr_sr_d = {addr_sr_q[ADDR_W-2:0], addr_sin};

      // A zero length field means the full 2^LEN_W beats
      target    = {len_reg_q == '0, len_reg_q};
      beat_take = counter_en && !stop_q && (beat_cnt_q != target);

      if (send_burst_len_data) begin
         len_reg_d    = len_sr_q;
         beat_cnt_d   = '0;
         len_loaded_d = 1'b1;
      end else if (beat_take) begin
         beat_cnt_d = beat_cnt_q + BEAT_ONE;
      end

      if (send_addr_data) begin
         cur_addr_d = addr_sr_q;
      end else if (counter_en && adder_en && !stop_q) begin
         cur_addr_d = cur_addr_q + STEP;
      end

      // Stop is evaluated on the next-state values so it rises with the final beat
      target_d = {len_reg_d == '0, len_reg_d};
      stop_d   = len_loaded_d && (beat_cnt_d == target_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_sr_q     <= '0;
         addr_sr_q    <= '0;
         len_reg_q    <= '0;
         len_loaded_q <= 1'b0;
         beat_cnt_q   <= '0;
         stop_q       <= 1'b0;
         cur_addr_q   <= '0;
      end else begin
         len_sr_q     <= len_sr_d;
         addr_sr_q    <= addr_sr_d;
         len_reg_q    <= len_reg_d;
         len_loaded_q <= len_loaded_d;
         beat_cnt_q   <= beat_cnt_d;
         stop_q       <= stop_d;
         cur_addr_q   <= cur_addr_d;
      end
   end

   burst_pts #(
      .ADDR_W (ADDR_W),
      .NIB_W  (NIB_W)
   ) u_pts (
      .clk       (clk),
      .rst       (rst),
      .clr       (addr_PTS_out_rst),
      .en        (addr_PTS_out_en),
      .load      (addr_PTS_out_load),
      .send      (addr_PTS_out_send_data),
      .word_sel  (addr_PTS_out_word_sel),
      .par_in    (cur_addr_q),
      .pts_bit   (pts_bit),
      .pts_valid (pts_valid),
      .pts_done  (pts_done)
   );

   assign addr_sout   = addr_sel ? pts_bit : addr_sin;
   assign stop_signal = stop_q;
   assign cur_addr    = cur_addr_q;

endmodule

// File: tb/tb_burst_addr_datapath.sv
// Self-checking bench for burst_addr_datapath: vector table for the beat sequence,
// hand-written sequences for PTS emission, wrap, full-length bursts and async reset.
module tb_burst_addr_datapath;
   import burst_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        len_sin, addr_sin;
   logic        burst_len_en, send_burst_len_data, initial_addr_en, send_addr_data;
   logic        counter_en, adder_en;
   logic        addr_PTS_out_rst, addr_PTS_out_en, addr_PTS_out_load, addr_PTS_out_send_data;
   logic [1:0]  addr_PTS_out_word_sel;
   logic        addr_sel;
   logic        stop_signal, addr_sout, pts_valid, pts_done;
   logic [15:0] cur_addr;

   always #5 clk = ~clk;

   burst_addr_datapath dut (
      .clk                    (clk),
      .rst                    (rst),
      .len_sin                (len_sin),
      .addr_sin               (addr_sin),
      .burst_len_en           (burst_len_en),
      .send_burst_len_data    (send_burst_len_data),
      .initial_addr_en        (initial_addr_en),
      .send_addr_data         (send_addr_data),
      .counter_en             (counter_en),
      .adder_en               (adder_en),
      .addr_PTS_out_rst       (addr_PTS_out_rst),
      .addr_PTS_out_en        (addr_PTS_out_en),
      .addr_PTS_out_load      (addr_PTS_out_load),
      .addr_PTS_out_send_data (addr_PTS_out_send_data),
      .addr_PTS_out_word_sel  (addr_PTS_out_word_sel),
      .addr_sel               (addr_sel),
      .stop_signal            (stop_signal),
      .addr_sout              (addr_sout),
      .pts_valid              (pts_valid),
      .pts_done               (pts_done),
      .cur_addr               (cur_addr)
   );

   localparam logic [11:0] B_BLE   = 12'h001;
   localparam logic [11:0] B_SLD   = 12'h002;
   localparam logic [11:0] B_IAE   = 12'h004;
   localparam logic [11:0] B_SAD   = 12'h008;
   localparam logic [11:0] B_CEN   = 12'h010;
   localparam logic [11:0] B_AEN   = 12'h020;
   localparam logic [11:0] B_PRST  = 12'h040;
   localparam logic [11:0] B_PEN   = 12'h080;
   localparam logic [11:0] B_PLOAD = 12'h100;
   localparam logic [11:0] B_PSEND = 12'h200;

   localparam int S_ADDR = 0, S_STOP = 1, S_SOUT = 2, S_VALID = 3, S_DONE = 4;

   typedef struct {
      string       name;
      int          sig;
      logic [15:0] val;
   } exp_t;

   typedef struct {
      logic [11:0] c;
      logic [15:0] exp_addr;
      logic        exp_stop;
   } vec_t;

   exp_t       sb[$];
   vec_t       vt[6];
   int         passed = 0;
   int         total  = 0;
   logic [1:0] ws_r   = 2'b00;
   logic       asel_r = 1'b0;

   task automatic apply(input logic [11:0] c, input logic ls, input logic as);
      burst_len_en           = c[0];
      send_burst_len_data    = c[1];
      initial_addr_en        = c[2];
      send_addr_data         = c[3];
      counter_en             = c[4];
      adder_en               = c[5];
      addr_PTS_out_rst       = c[6];
      addr_PTS_out_en        = c[7];
      addr_PTS_out_load      = c[8];
      addr_PTS_out_send_data = c[9];
      addr_PTS_out_word_sel  = ws_r;
      addr_sel               = asel_r;
      len_sin                = ls;
      addr_sin               = as;
   endtask

   task automatic exp_push(input string n, input int s, input logic [15:0] v);
      exp_t e;
      e.name = n;
      e.sig  = s;
      e.val  = v;
      sb.push_back(e);
   endtask

   function automatic logic [15:0] actual(input int s);
      case (s)
         S_ADDR:  return cur_addr;
         S_STOP:  return {15'd0, stop_signal};
         S_SOUT:  return {15'd0, addr_sout};
         S_VALID: return {15'd0, pts_valid};
         default: return {15'd0, pts_done};
      endcase
   endfunction

   task automatic drain();
      exp_t        e;
      logic [15:0] a;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         a = actual(e.sig);
         total++;
         if (a === e.val) passed++;
         else $display("FAIL %s: got %h, expected %h", e.name, a, e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic shift_len(input logic [3:0] v);
      for (int i = 3; i >= 0; i--) begin
         apply(B_BLE, v[i], 1'b0);
         tick();
      end
      apply(B_SLD, 1'b0, 1'b0);
      tick();
   endtask

   task automatic shift_addr(input logic [15:0] v);
      for (int i = 15; i >= 0; i--) begin
         apply(B_IAE, 1'b0, v[i]);
         tick();
      end
   endtask

   task automatic load_addr(input logic [15:0] v);
      shift_addr(v);
      apply(B_SAD, 1'b0, 1'b0);
      exp_push("load_addr", S_ADDR, v);
      tick();
   endtask

   task automatic pts_load();
      apply(B_PEN | B_PLOAD, 1'b0, 1'b0);
      exp_push("pts_load_valid", S_VALID, 16'd0);
      exp_push("pts_load_sout", S_SOUT, 16'd0);
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected summary before it");
      $fatal(1);
   end

   initial begin
      logic [15:0] pat;

      rst = 1'b1;
      apply(12'd0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      exp_push("rst_addr", S_ADDR, 16'd0);
      exp_push("rst_stop", S_STOP, 16'd0);
      exp_push("rst_valid", S_VALID, 16'd0);
      exp_push("rst_done", S_DONE, 16'd0);
      exp_push("rst_sout_hi", S_SOUT, 16'd1);
      drain();
      apply(12'd0, 1'b0, 1'b0);
      #1;
      exp_push("rst_sout_lo", S_SOUT, 16'd0);
      drain();
      rst = 1'b0;
      tick();

      // Length 3, base A5C0, three beats (first beat coincides with the address load)
      vt[0] = '{B_SAD | B_CEN, 16'hA5C0, 1'b0};
      vt[1] = '{B_CEN | B_AEN, 16'hA5C1, 1'b0};
      vt[2] = '{B_CEN | B_AEN, 16'hA5C2, 1'b1};
      vt[3] = '{12'd0,         16'hA5C2, 1'b1};
      vt[4] = '{B_CEN,         16'hA5C2, 1'b1};
      vt[5] = '{B_SLD,         16'hA5C2, 1'b0};
      shift_len(4'b0011);
      shift_addr(16'hA5C0);
      for (int i = 0; i < 6; i++) begin
         apply(vt[i].c, 1'b0, 1'b0);
         exp_push($sformatf("beat%0d_addr", i), S_ADDR, vt[i].exp_addr);
         exp_push($sformatf("beat%0d_stop", i), S_STOP, {15'd0, vt[i].exp_stop});
         tick();
      end

      // Address wrap
      load_addr(16'hFFFF);
      apply(B_CEN | B_AEN, 1'b0, 1'b0);
      exp_push("wrap_addr", S_ADDR, 16'h0000);
      tick();

      // Full 16-bit emission of A5C1
      load_addr(16'hA5C1);
      ws_r   = WORD_SEL_ALL;
      asel_r = 1'b1;
      pts_load();
      pat = 16'hA5C1;
      for (int i = 0; i < 16; i++) begin
         apply(B_PEN | B_PSEND, 1'b0, 1'b0);
         exp_push($sformatf("full_bit%0d", i), S_SOUT, {15'd0, pat[15-i]});
         exp_push($sformatf("full_valid%0d", i), S_VALID, 16'd1);
         exp_push($sformatf("full_done%0d", i), S_DONE, 16'd0);
         tick();
      end
      apply(B_PEN, 1'b0, 1'b0);
      exp_push("full_done_pulse", S_DONE, 16'd1);
      exp_push("full_valid_end", S_VALID, 16'd0);
      exp_push("full_sout_end", S_SOUT, 16'd0);
      tick();
      apply(B_PEN, 1'b0, 1'b0);
      exp_push("full_done_clear", S_DONE, 16'd0);
      tick();

      // Single nibble of F0F0
      load_addr(16'hF0F0);
      ws_r = 2'b00;
      pts_load();
      for (int i = 0; i < 4; i++) begin
         apply(B_PEN | B_PSEND, 1'b0, 1'b0);
         exp_push($sformatf("nib_bit%0d", i), S_SOUT, 16'd1);
         exp_push($sformatf("nib_valid%0d", i), S_VALID, 16'd1);
         tick();
      end
      apply(B_PEN | B_PSEND, 1'b0, 1'b0);
      exp_push("nib_done", S_DONE, 16'd1);
      exp_push("nib_valid_end", S_VALID, 16'd0);
      tick();
      apply(B_PEN | B_PSEND, 1'b0, 1'b0);
      exp_push("nib_valid_after", S_VALID, 16'd0);
      exp_push("nib_sout_after", S_SOUT, 16'd0);
      exp_push("nib_done_after", S_DONE, 16'd0);
      tick();

      // Load and send together: load wins and emission restarts at the MSB
      ws_r = WORD_SEL_ALL;
      pts_load();
      apply(B_PEN | B_PSEND, 1'b0, 1'b0);
      exp_push("ls_first_bit", S_SOUT, 16'd1);
      tick();
      apply(B_PEN | B_PLOAD | B_PSEND, 1'b0, 1'b0);
      exp_push("ls_valid", S_VALID, 16'd0);
      exp_push("ls_sout", S_SOUT, 16'd0);
      tick();
      pat = 16'hF0F0;
      for (int i = 0; i < 5; i++) begin
         apply(B_PEN | B_PSEND, 1'b0, 1'b0);
         exp_push($sformatf("ls_bit%0d", i), S_SOUT, {15'd0, pat[15-i]});
         exp_push($sformatf("ls_valid%0d", i), S_VALID, 16'd1);
         tick();
      end

      // Shifter clear acts without the enable
      apply(B_PRST, 1'b0, 1'b0);
      exp_push("clr_valid", S_VALID, 16'd0);
      exp_push("clr_sout", S_SOUT, 16'd0);
      tick();
      apply(B_PEN | B_PSEND, 1'b0, 1'b0);
      exp_push("clr_send_valid", S_VALID, 16'd0);
      exp_push("clr_send_done", S_DONE, 16'd0);
      tick();

      // Length 0 gives 16 beats; further beats are ignored
      asel_r = 1'b0;
      shift_len(4'b0000);
      for (int i = 1; i <= 17; i++) begin
         apply(B_CEN, 1'b0, 1'b0);
         exp_push($sformatf("len0_stop%0d", i), S_STOP, (i >= 16) ? 16'd1 : 16'd0);
         tick();
      end

      // Asynchronous reset in the middle of an emission
      load_addr(16'hA5C1);
      asel_r = 1'b1;
      pts_load();
      pat = 16'hA5C1;
      for (int i = 0; i < 7; i++) begin
         apply(B_PEN | B_PSEND, 1'b0, 1'b0);
         exp_push($sformatf("mid_bit%0d", i), S_SOUT, {15'd0, pat[15-i]});
         tick();
      end
      exp_push("mid_stop_held", S_STOP, 16'd1);
      exp_push("mid_valid", S_VALID, 16'd1);
      drain();
      #2;
      rst    = 1'b1;
      asel_r = 1'b0;
      apply(12'd0, 1'b0, 1'b1);
      #1;
      exp_push("arst_stop", S_STOP, 16'd0);
      exp_push("arst_valid", S_VALID, 16'd0);
      exp_push("arst_done", S_DONE, 16'd0);
      exp_push("arst_addr", S_ADDR, 16'd0);
      exp_push("arst_sout_hi", S_SOUT, 16'd1);
      drain();
      apply(12'd0, 1'b0, 1'b0);
      #1;
      exp_push("arst_sout_lo", S_SOUT, 16'd0);
      drain();
      asel_r = 1'b1;
      apply(12'd0, 1'b0, 1'b1);
      #1;
      exp_push("arst_pts_bit", S_SOUT, 16'd0);
      drain();
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply(B_CEN, 1'b0, 1'b0);
      exp_push("post_rst_stop", S_STOP, 16'd0);
      tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
